// File: rtl/lisp_heap_pkg.sv
// ============================================================================
// Module      : lisp_defs (package)
// Description : Shared constants and types for the LISP heap: the NIL word,
//               request opcodes, response error codes and controller states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lisp_defs;

    // Word stored at address 0 and returned for reads of address 0
    localparam logic [15:0] LISP_NIL = 16'hFFFF;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_CONS  = 2'd2,
        OP_CLEAR = 2'd3
    } heap_op_e;

    typedef enum logic [3:0] {
        ERR_NONE     = 4'd0,
        ERR_READONLY = 4'd1,
        ERR_OOM      = 4'd2
    } heap_err_e;

    typedef enum logic [2:0] {
        ST_CLEAR    = 3'd0,
        ST_IDLE     = 3'd1,
        ST_ACCESS   = 3'd2,
        ST_CONS_CDR = 3'd3,
        ST_RESPOND  = 3'd4
    } heap_state_e;

endpackage

`default_nettype wire

// File: rtl/lisp_heap_ram.sv
// ============================================================================
// Module      : heap_ram
// Description : Single-port heap storage, synchronous write, registered
//               read-first output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module heap_ram #(
    parameter  int DataWidth  = 16,
    parameter  int MemorySize = 256,
    localparam int AddrWidth  = $clog2(MemorySize)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AddrWidth-1:0] addr,
    input  logic [DataWidth-1:0] wdata,
    output logic [DataWidth-1:0] rdata
);

    logic [DataWidth-1:0] r_mem [MemorySize];
    logic [DataWidth-1:0] r_rdata;

    // Write the addressed word and register the old contents for reading
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        r_rdata <= r_mem[addr];
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/lisp_heap.sv
// ============================================================================
// Module      : lisp_heap
// Description : LISP cons heap controller: clear sweep, word read/write with
//               read-only NIL cell, and bump-pointer CONS allocation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lisp_heap
    import lisp_defs::*;
#(
    parameter  int DataWidth  = 16,
    parameter  int MemorySize = 256,
    localparam int AddrWidth  = $clog2(MemorySize)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  heap_op_e             req_op,
    input  logic [AddrWidth-1:0] req_addr,
    input  logic [DataWidth-1:0] req_data,
    input  logic [DataWidth-1:0] req_data2,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DataWidth-1:0] rsp_data,
    output heap_err_e            rsp_error,
    output logic                 init_done,
    output logic [AddrWidth-1:0] free_ptr
);

    localparam logic [AddrWidth-1:0] c_last_addr = AddrWidth'(MemorySize - 1);
    localparam logic [AddrWidth-1:0] c_cons_max  = AddrWidth'(MemorySize - 2);

    heap_state_e          r_state, w_next_state;
    logic [AddrWidth-1:0] r_sweep;
    logic                 r_clear_rsp;
    logic                 r_phase;
    heap_op_e             r_op;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_data, r_data2;
    logic [DataWidth-1:0] r_rsp_data;
    heap_err_e            r_rsp_err;
    logic                 r_init_done;
    logic [AddrWidth-1:0] r_free_ptr;

    logic                 w_ram_we;
    logic [AddrWidth-1:0] w_ram_addr;
    logic [DataWidth-1:0] w_ram_wdata, w_ram_rdata;
    logic                 w_oom;
    logic [AddrWidth:0]   w_ptr_sum;
    logic [AddrWidth-1:0] w_ptr_next;

    heap_ram #(
        .DataWidth  (DataWidth),
        .MemorySize (MemorySize)
    ) u_ram (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (w_ram_wdata),
        .rdata (w_ram_rdata)
    );

    // A pair needs two free words; the pointer saturates instead of wrapping
    assign w_oom      = (r_free_ptr > c_cons_max);
    assign w_ptr_sum  = {1'b0, r_free_ptr} + (AddrWidth+1)'(2);
    assign w_ptr_next = (w_ptr_sum > {1'b0, c_last_addr}) ? c_last_addr
                                                          : w_ptr_sum[AddrWidth-1:0];

    // State register; reset forces a fresh clear sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and RAM port control; each access state spends a second
    // cycle so that the response leaves one edge after the last RAM action
    always_comb begin
        w_next_state = r_state;
        w_ram_we     = 1'b0;
        w_ram_addr   = r_addr;
        w_ram_wdata  = r_data;
        case (r_state)
            ST_CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_sweep;
                w_ram_wdata = (r_sweep == '0) ? DataWidth'(LISP_NIL) : '0;
                if (r_sweep == c_last_addr) begin
                    w_next_state = r_clear_rsp ? ST_RESPOND : ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    w_next_state = (req_op == OP_CLEAR) ? ST_CLEAR : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!r_phase) begin
                    case (r_op)
                        OP_WRITE: w_ram_we = (r_addr != '0);
                        OP_CONS: begin
                            if (!w_oom) begin
                                w_ram_we     = 1'b1;
                                w_ram_addr   = r_free_ptr;
                                w_next_state = ST_CONS_CDR;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    w_next_state = ST_RESPOND;
                end
            end
            ST_CONS_CDR: begin
                if (!r_phase) begin
                    w_ram_we    = 1'b1;
                    w_ram_addr  = r_free_ptr + AddrWidth'(1);
                    w_ram_wdata = r_data2;
                end else begin
                    w_next_state = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_CLEAR;
        endcase
    end

    // Request capture, sweep progress, allocation pointer and response words
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sweep     <= '0;
            r_clear_rsp <= 1'b0;
            r_phase     <= 1'b0;
            r_op        <= OP_READ;
            r_addr      <= '0;
            r_data      <= '0;
            r_data2     <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= ERR_NONE;
            r_init_done <= 1'b0;
            r_free_ptr  <= '0;
        end else begin
            r_phase <= (w_next_state == r_state);
            case (r_state)
                ST_CLEAR: begin
                    r_sweep <= r_sweep + AddrWidth'(1);
                    if (r_sweep == c_last_addr) begin
                        r_init_done <= 1'b1;
                        r_free_ptr  <= AddrWidth'(1);
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_addr  <= req_addr;
                        r_data  <= req_data;
                        r_data2 <= req_data2;
                        if (req_op == OP_CLEAR) begin
                            r_init_done <= 1'b0;
                            r_clear_rsp <= 1'b1;
                            r_sweep     <= '0;
                            r_free_ptr  <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (r_phase) begin
                        case (r_op)
                            OP_READ: begin
                                r_rsp_data <= w_ram_rdata;
                                r_rsp_err  <= ERR_NONE;
                            end
                            OP_WRITE: begin
                                r_rsp_err <= (r_addr == '0) ? ERR_READONLY : ERR_NONE;
                            end
                            default: r_rsp_err <= ERR_OOM;
                        endcase
                    end
                end
                ST_CONS_CDR: begin
                    if (r_phase) begin
                        r_rsp_data <= DataWidth'(r_free_ptr);
                        r_rsp_err  <= ERR_NONE;
                        r_free_ptr <= w_ptr_next;
                    end
                end
                ST_RESPOND: begin
                    if (rsp_ready) begin
                        r_rsp_data  <= '0;
                        r_rsp_err   <= ERR_NONE;
                        r_clear_rsp <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESPOND);
    assign rsp_data  = r_rsp_data;
    assign rsp_error = r_rsp_err;
    assign init_done = r_init_done;
    assign free_ptr  = r_free_ptr;

endmodule

`default_nettype wire

// File: tb/tb_lisp_heap.sv
// ============================================================================
// Module      : tb_lisp_heap
// Description : Self-checking bench for lisp_heap: a 256-word heap and an
//               8-word heap checked against an abstract heap model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lisp_heap;
    import lisp_defs::*;

    typedef struct {
        int          unit;
        logic [15:0] data;
        heap_err_e   err;
        logic [7:0]  fp;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_u     [2];
    logic        req_valid [2];
    logic        req_ready [2];
    heap_op_e    req_op    [2];
    logic [7:0]  req_addr  [2];
    logic [15:0] req_data  [2];
    logic [15:0] req_data2 [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_data  [2];
    heap_err_e   rsp_error [2];
    logic        init_done [2];
    logic [7:0]  fp0;
    logic [2:0]  fp1;
    logic [7:0]  fp        [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [15:0] mm  [2][256];
    int          mfp [2];
    int          msz [2] = '{256, 8};
    exp_t        q [$];
    exp_t        cur [2];
    logic        in_rsp [2] = '{1'b0, 1'b0};
    logic        have   [2] = '{1'b0, 1'b0};
    logic [15:0] last_data [2];
    heap_err_e   last_err  [2];

    assign fp[0] = fp0;
    assign fp[1] = {5'b0, fp1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    lisp_heap #(.DataWidth(16), .MemorySize(256)) dut0 (
        .clk(clk), .rst(rst_u[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
        .req_addr(req_addr[0]), .req_data(req_data[0]), .req_data2(req_data2[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .rsp_error(rsp_error[0]), .init_done(init_done[0]), .free_ptr(fp0)
    );

    lisp_heap #(.DataWidth(16), .MemorySize(8)) dut1 (
        .clk(clk), .rst(rst_u[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
        .req_addr(req_addr[1][2:0]), .req_data(req_data[1]), .req_data2(req_data2[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .rsp_error(rsp_error[1]), .init_done(init_done[1]), .free_ptr(fp1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Abstract heap: cleared image, bump allocator with saturating pointer
    task automatic model_clear(input int u);
        for (int i = 0; i < 256; i++) mm[u][i] = 16'h0000;
        mm[u][0] = LISP_NIL;
        mfp[u]   = 1;
    endtask

    function automatic exp_t model_apply(input int u, input heap_op_e o, input int a,
                                         input logic [15:0] d1, input logic [15:0] d2);
        exp_t e;
        e.unit = u; e.data = 16'h0; e.err = ERR_NONE; e.lat = 2; e.acc = 0;
        case (o)
            OP_READ:  e.data = mm[u][a];
            OP_WRITE: if (a == 0) e.err = ERR_READONLY; else mm[u][a] = d1;
            OP_CONS: begin
                if (mfp[u] > msz[u] - 2) begin
                    e.err = ERR_OOM;
                end else begin
                    mm[u][mfp[u]]     = d1;
                    mm[u][mfp[u] + 1] = d2;
                    e.data = 16'(mfp[u]);
                    e.lat  = 3;
                    mfp[u] = (mfp[u] + 2 > msz[u] - 1) ? msz[u] - 1 : mfp[u] + 2;
                end
            end
            default: begin
                for (int i = 0; i < 256; i++) mm[u][i] = 16'h0000;
                mm[u][0] = LISP_NIL;
                mfp[u]   = 1;
                e.lat    = msz[u];
            end
        endcase
        e.fp = 8'(mfp[u]);
        return e;
    endfunction

    // Compare every visible response cycle against the model's expectation
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rsp_valid[u]) begin
                if (!in_rsp[u]) begin
                    if (q.size() == 0 || q[0].unit != u) begin
                        check($sformatf("unexpected_rsp_u%0d", u), 1, 0);
                        have[u] = 1'b0;
                    end else begin
                        cur[u]  = q.pop_front();
                        have[u] = 1'b1;
                        check($sformatf("rsp_latency_u%0d", u), cyc - cur[u].acc, cur[u].lat);
                    end
                    last_data[u] = rsp_data[u];
                    last_err[u]  = rsp_error[u];
                end
                if (have[u]) begin
                    check($sformatf("rsp_data_u%0d", u), rsp_data[u], cur[u].data);
                    check($sformatf("rsp_error_u%0d", u), rsp_error[u], cur[u].err);
                    check($sformatf("free_ptr_u%0d", u), fp[u], cur[u].fp);
                end
                check($sformatf("req_ready_in_rsp_u%0d", u), req_ready[u], 0);
            end
            in_rsp[u] = rsp_valid[u];
        end
    end

    task automatic do_op(input int u, input heap_op_e o, input int a,
                         input logic [15:0] d1, input logic [15:0] d2, input int hold);
        exp_t e;
        int   n;
        req_valid[u] = 1'b1; req_op[u] = o; req_addr[u] = 8'(a);
        req_data[u] = d1; req_data2[u] = d2;
        n = 0;
        while (!req_ready[u] && n < 400) begin @(negedge clk); n++; end
        if (!req_ready[u]) begin
            check("accept_timeout", 1, 0);
            req_valid[u] = 1'b0;
            return;
        end
        e = model_apply(u, o, a, d1, d2);
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
        req_valid[u] = 1'b0;
        n = 0;
        while (!rsp_valid[u] && n < 400) begin @(negedge clk); n++; end
        if (!rsp_valid[u]) begin
            check("rsp_timeout", 1, 0);
            void'(q.pop_front());
            return;
        end
        repeat (hold) @(negedge clk);
        rsp_ready[u] = 1'b1;
        @(negedge clk);
        rsp_ready[u] = 1'b0;
    endtask

    task automatic wait_init(input int u);
        int n = 0;
        while (!init_done[u] && n < 400) begin @(negedge clk); n++; end
        check($sformatf("init_timeout_u%0d", u), init_done[u], 1);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_u[u] = 1'b1; req_valid[u] = 1'b0; req_op[u] = OP_READ;
            req_addr[u] = 8'h0; req_data[u] = 16'h0; req_data2[u] = 16'h0;
            rsp_ready[u] = 1'b0;
            model_clear(u);
        end
        @(negedge clk);
        check("rst_req_ready", req_ready[0], 0);
        check("rst_rsp_valid", rsp_valid[0], 0);
        check("rst_rsp_data", rsp_data[0], 0);
        check("rst_rsp_error", rsp_error[0], ERR_NONE);
        check("rst_init_done", init_done[0], 0);
        check("rst_free_ptr", fp0, 0);
        rst_u[0] = 1'b0; rst_u[1] = 1'b0;

        // Sweep of 256 words: init_done must rise on exactly the 256th edge
        repeat (255) @(negedge clk);
        check("init_before_256", init_done[0], 0);
        @(negedge clk);
        check("init_at_256", init_done[0], 1);
        check("free_ptr_after_init", fp0, 1);

        do_op(0, OP_READ, 0, 16'h0, 16'h0, 0);
        check("read0_nil", last_data[0], LISP_NIL);
        do_op(0, OP_READ, 5, 16'h0, 16'h0, 0);
        check("read5_zero", last_data[0], 16'h0000);

        do_op(0, OP_WRITE, 4, 16'h789A, 16'h0, 0);
        do_op(0, OP_READ, 4, 16'h0, 16'h0, 0);
        check("read4_789a", last_data[0], 16'h789A);

        do_op(0, OP_CONS, 0, 16'h0004, LISP_NIL, 0);
        check("cons1_base", last_data[0], 16'h0001);
        check("cons1_free_ptr", fp0, 3);
        do_op(0, OP_READ, 1, 16'h0, 16'h0, 0);
        check("cons1_car", last_data[0], 16'h0004);
        do_op(0, OP_READ, 2, 16'h0, 16'h0, 0);
        check("cons1_cdr", last_data[0], LISP_NIL);
        do_op(0, OP_CONS, 0, 16'h1111, 16'h2222, 0);
        check("cons2_base", last_data[0], 16'h0003);

        do_op(0, OP_WRITE, 0, 16'h1234, 16'h0, 10);
        check("write0_readonly", last_err[0], ERR_READONLY);
        do_op(0, OP_READ, 0, 16'h0, 16'h0, 3);
        check("read0_still_nil", last_data[0], LISP_NIL);

        do_op(0, OP_CLEAR, 0, 16'h0, 16'h0, 0);
        check("clear_free_ptr", fp0, 1);
        check("clear_init_done", init_done[0], 1);
        do_op(0, OP_READ, 4, 16'h0, 16'h0, 0);

        // Reset between the car and cdr writes of a CONS
        req_valid[0] = 1'b1; req_op[0] = OP_CONS; req_data[0] = 16'hBEEF; req_data2[0] = 16'hCAFE;
        begin
            int n = 0;
            while (!req_ready[0] && n < 50) begin @(negedge clk); n++; end
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst_u[0] = 1'b1;
        model_clear(0);
        #1;
        check("midrst_rsp_valid", rsp_valid[0], 0);
        check("midrst_init_done", init_done[0], 0);
        check("midrst_free_ptr", fp0, 0);
        @(negedge clk);
        rst_u[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_sweep_running", init_done[0], 0);
        wait_init(0);
        do_op(0, OP_READ, 1, 16'h0, 16'h0, 0);
        check("midrst_read1", last_data[0], 16'h0000);

        // 8-word heap: allocations 1, 3, 5 then out of memory
        wait_init(1);
        do_op(1, OP_WRITE, 7, 16'hABCD, 16'h0, 0);
        do_op(1, OP_CONS, 0, 16'h0A0A, 16'h0B0B, 0);
        check("small_cons1", last_data[1], 16'h0001);
        do_op(1, OP_CONS, 0, 16'h0C0C, 16'h0D0D, 0);
        check("small_cons2", last_data[1], 16'h0003);
        do_op(1, OP_CONS, 0, 16'h0E0E, 16'h0F0F, 0);
        check("small_cons3", last_data[1], 16'h0005);
        do_op(1, OP_CONS, 0, 16'h5555, 16'h6666, 0);
        check("small_cons4_oom", last_err[1], ERR_OOM);
        check("small_free_ptr", fp1, 7);
        do_op(1, OP_READ, 7, 16'h0, 16'h0, 0);
        check("small_mem7", last_data[1], 16'hABCD);
        do_op(1, OP_READ, 6, 16'h0, 16'h0, 0);

        repeat (4) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
